// File: rtl/pattern_fb_writer.sv
// rtl/pattern_fb_writer.sv - framebuffer pattern writer with restart, latched mode/seed and back-pressure
//
// Fills an H_VISIBLE x V_VISIBLE row-major framebuffer with an index pattern
// selected by mode and offset by seed (both latched at frame start).  One pixel
// is issued per cycle in which wr_ready is high; addresses ascend 0..H*V-1.
//
// Ports:
//   clk          pixel clock
//   resetn       asynchronous active-low reset
//   start        request a new frame (honoured in IDLE or DONE only)
//   mode[2:0]    pattern select, latched at frame start
//   seed         pattern offset, latched at frame start
//   wr_ready     framebuffer accepts a write this cycle
//   we           registered write strobe
//   waddr        registered write address
//   wdata        registered write data (pixel index)
//   busy         high while writing a frame
//   frame_done   high from frame completion until the next accepted start
//   frame_count  completed frame counter (only with FBW_FRAME_COUNT_EN defined)
//
// Build option: define FBW_FRAME_COUNT_EN to add the frame_count port and counter.

`timescale 1ns/1ps

module pattern_fb_writer #(
   parameter int H_VISIBLE  = 320,
   parameter int V_VISIBLE  = 240,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 17,
   parameter int AUTO_START = 1,
   parameter int CHK_BIT    = 3
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [2:0]            mode,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic                  wr_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  frame_done
`ifdef FBW_FRAME_COUNT_EN
   ,
   output logic [15:0]           frame_count
`endif
);

   localparam int XW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
   localparam int YW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

   // Fixed-point scale factors mapping the coordinate range onto 0..2^DATA_WIDTH-1
   localparam logic [31:0] SX = 32'(((1 << DATA_WIDTH) * 4096) / H_VISIBLE);
   localparam logic [31:0] SY = 32'(((1 << DATA_WIDTH) * 4096) / V_VISIBLE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WR   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_n;
   logic                    first_q;
   logic [XW-1:0]           x;
   logic [YW-1:0]           y;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [2:0]              mode_q;
   logic [DATA_WIDTH-1:0]   seed_q;
   logic                    load;
   logic                    issue;
   logic                    last_pix;
   logic                    last_col;
   logic [DATA_WIDTH-1:0]   sx;
   logic [DATA_WIDTH-1:0]   sy;
   logic [DATA_WIDTH-1:0]   pix;

   assign last_col = (x == XW'(H_VISIBLE - 1));
   assign last_pix = last_col && (y == YW'(V_VISIBLE - 1));

   // Scaled coordinates; the product never exceeds 2^(DATA_WIDTH+12)
   assign sx = DATA_WIDTH'((32'(x) * SX) >> 12);
   assign sy = DATA_WIDTH'((32'(y) * SY) >> 12);

   always_comb begin
      pix = seed_q;
      case (mode_q)
         3'd0:    pix = sx + sy + seed_q;
         3'd1:    pix = (sx ^ sy) + seed_q;
         3'd2:    pix = sx + seed_q;
         3'd3:    pix = sy + seed_q;
         3'd4:    pix = (x[CHK_BIT] ^ y[CHK_BIT]) ? seed_q : ~seed_q;
         default: pix = seed_q;
      endcase
   end

   // Next-state and control decode
   always_comb begin
      state_n = state;
      load    = 1'b0;
      issue   = 1'b0;
      case (state)
         S_IDLE: begin
            // first_q is only high on the first clock after reset release
            if (start || ((AUTO_START != 0) && first_q)) begin
               load    = 1'b1;
               state_n = S_WR;
            end
         end
         S_WR: begin
            // start is deliberately not sampled here: requests during a frame are dropped
            if (wr_ready) begin
               issue = 1'b1;
               if (last_pix) begin
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = S_WR;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= S_IDLE;
         first_q <= 1'b1;
      end else begin
         state   <= state_n;
         first_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x          <= '0;
         y          <= '0;
         addr       <= '0;
         mode_q     <= '0;
         seed_q     <= '0;
         we         <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         we <= 1'b0;
         if (load) begin
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            mode_q     <= mode;
            seed_q     <= seed;
            frame_done <= 1'b0;
            busy       <= 1'b1;
         end
         if (issue) begin
            we    <= 1'b1;
            waddr <= addr;
            wdata <= pix;
            addr  <= addr + ADDR_WIDTH'(1);
            if (last_col) begin
               x <= '0;
               y <= y + YW'(1);
            end else begin
               x <= x + XW'(1);
            end
            if (last_pix) begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
            end
         end
      end
   end

`ifdef FBW_FRAME_COUNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_count <= 16'd0;
      end else if (issue && last_pix) begin
         frame_count <= frame_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pattern_fb_writer.sv
// tb/tb_pattern_fb_writer.sv - randomized self-checking bench for pattern_fb_writer

`timescale 1ns/1ps

module tb_pattern_fb_writer;

   localparam int TH   = 40;
   localparam int TV   = 12;
   localparam int NPIX = TH * TV;
   localparam int AW   = 9;

   logic          clk;
   logic          resetn;
   logic          start;
   logic [2:0]    mode;
   logic [7:0]    seed;
   logic          wr_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic          busy;
   logic          frame_done;
`ifdef FBW_FRAME_COUNT_EN
   logic [15:0]   frame_count;
`endif

   int errors;
   int checks;
   int exp_frames;

   pattern_fb_writer #(
      .H_VISIBLE  (TH),
      .V_VISIBLE  (TV),
      .DATA_WIDTH (8),
      .ADDR_WIDTH (AW),
      .AUTO_START (1),
      .CHK_BIT    (3)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .mode       (mode),
      .seed       (seed),
      .wr_ready   (wr_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef FBW_FRAME_COUNT_EN
      ,
      .frame_count(frame_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference pixel value from linear index, straight from the pattern definitions
   function automatic logic [7:0] model_pix(input int idx, input logic [2:0] m, input logic [7:0] s);
      int px;
      int py;
      logic [7:0] sx8;
      logic [7:0] sy8;
      logic [7:0] r;
      px  = idx % TH;
      py  = idx / TH;
      sx8 = 8'((px * ((256 * 4096) / TH)) >> 12);
      sy8 = 8'((py * ((256 * 4096) / TV)) >> 12);
      case (m)
         3'd0:    r = sx8 + sy8 + s;
         3'd1:    r = (sx8 ^ sy8) + s;
         3'd2:    r = sx8 + s;
         3'd3:    r = sy8 + s;
         3'd4:    r = ((((px >> 3) & 1) ^ ((py >> 3) & 1)) != 0) ? s : ~s;
         default: r = s;
      endcase
      return r;
   endfunction

   function automatic logic next_ready(input int rmode, input logic cur);
      if (rmode == 1) return ~cur;
      if (rmode == 2) return ($urandom_range(0, 3) != 0);
      return 1'b1;
   endfunction

   // Pulse start while in DONE; check the frame-entry edge
   task automatic start_frame(input logic [2:0] m, input logic [7:0] s);
      mode  = m;
      seed  = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || frame_done !== 1'b0 || we !== 1'b0)
         $display("FAIL frame_entry: busy=%0b frame_done=%0b we=%0b, required busy=1 frame_done=0 we=0",
                  busy, frame_done, we);
      if (busy !== 1'b1 || frame_done !== 1'b0 || we !== 1'b0) errors++;
   endtask

   // Drive wr_ready per rmode and check every strobe against the model.
   // glitch_at: pulse start (with mode=2) once that many pixels are out; stop_at: return early.
   task automatic run_frame(input logic [2:0] m, input logic [7:0] s, input int rmode,
                            input int glitch_at, input int stop_at);
      int   n;
      int   budget;
      logic prev_ready;
      logic prev_busy;
      logic glitch_live;
      logic glitch_done;
      logic [7:0] exp_d;
      n           = 0;
      budget      = 0;
      glitch_live = 1'b0;
      glitch_done = 1'b0;
      wr_ready    = 1'b1;
      if (rmode == 2) wr_ready = next_ready(2, 1'b1);
      prev_busy   = busy;
      prev_ready  = wr_ready;
      while (n < NPIX && budget < NPIX * 4 + 20) begin
         @(posedge clk); #1;
         budget++;
         if (glitch_live) begin
            start       = 1'b0;
            glitch_live = 1'b0;
         end
         if (prev_busy) begin
            checks++;
            if (we !== prev_ready) begin
               errors++;
               $display("FAIL we_follows_ready: we=%0b, required %0b (pixel %0d)", we, prev_ready, n);
            end
         end
         if (we === 1'b1) begin
            exp_d = model_pix(n, m, s);
            checks++;
            if (waddr !== AW'(n)) begin
               errors++;
               $display("FAIL waddr: got %0d, required %0d", waddr, n);
            end
            checks++;
            if (wdata !== exp_d) begin
               errors++;
               $display("FAIL wdata: addr %0d mode %0d got %02h, required %02h", n, m, wdata, exp_d);
            end
            n++;
            checks++;
            if (n == NPIX) begin
               if (frame_done !== 1'b1 || busy !== 1'b0) begin
                  errors++;
                  $display("FAIL last_edge_flags: frame_done=%0b busy=%0b, required 1 0", frame_done, busy);
               end
            end else begin
               if (frame_done !== 1'b0 || busy !== 1'b1) begin
                  errors++;
                  $display("FAIL mid_frame_flags: frame_done=%0b busy=%0b, required 0 1", frame_done, busy);
               end
            end
         end
         if (stop_at >= 0 && n >= stop_at) break;
         if (n == glitch_at && !glitch_done) begin
            start       = 1'b1;
            mode        = 3'd2;
            glitch_live = 1'b1;
            glitch_done = 1'b1;
         end
         prev_busy  = busy;
         wr_ready   = next_ready(rmode, wr_ready);
         prev_ready = wr_ready;
      end
      if (stop_at < 0) begin
         checks++;
         if (n != NPIX) begin
            errors++;
            $display("FAIL frame_len: got %0d strobes, required %0d", n, NPIX);
         end
         @(posedge clk); #1;
         start = 1'b0;
         checks++;
         if (we !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL after_frame: we=%0b busy=%0b frame_done=%0b, required 0 0 1", we, busy, frame_done);
         end
         exp_frames++;
`ifdef FBW_FRAME_COUNT_EN
         checks++;
         if (frame_count !== 16'(exp_frames)) begin
            errors++;
            $display("FAIL frame_count: got %0d, required %0d", frame_count, exp_frames);
         end
`endif
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      start    = 1'b0;
      mode     = 3'd0;
      seed     = 8'd0;
      wr_ready = 1'b1;
      exp_frames = 0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (we !== 1'b0 || waddr !== '0 || wdata !== 8'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: we=%0b waddr=%0d wdata=%02h busy=%0b frame_done=%0b, required all 0",
                  we, waddr, wdata, busy, frame_done);
      end
`ifdef FBW_FRAME_COUNT_EN
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_frame_count: got %0d, required 0", frame_count);
      end
`endif
   endtask

   task automatic test_auto_frame();
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || we !== 1'b0) begin
         errors++;
         $display("FAIL auto_start: busy=%0b we=%0b, required 1 0", busy, we);
      end
      run_frame(3'd0, 8'd0, 0, -1, -1);
   endtask

   task automatic test_done_hold();
      logic [7:0] last_d;
      last_d = model_pix(NPIX - 1, 3'd0, 8'd0);
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (we !== 1'b0 || waddr !== AW'(NPIX - 1) || wdata !== last_d || busy !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold: we=%0b waddr=%0d wdata=%02h busy=%0b done=%0b, required 0 %0d %02h 0 1",
                     we, waddr, wdata, busy, frame_done, NPIX - 1, last_d);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] s;
      s = 8'($urandom);
      start_frame(3'd0, s);
      run_frame(3'd0, s, 1, -1, -1);
   endtask

   task automatic test_checker();
      start_frame(3'd4, 8'h0F);
      run_frame(3'd4, 8'h0F, 2, -1, -1);
   endtask

   task automatic test_modes();
      logic [7:0] s;
      for (int m = 0; m < 8; m++) begin
         s = 8'($urandom);
         start_frame(3'(m), s);
         run_frame(3'(m), s, 2, -1, -1);
      end
   endtask

   task automatic test_start_ignored();
      logic [7:0] s;
      s = 8'($urandom);
      start_frame(3'd0, s);
      run_frame(3'd0, s, 2, 100, -1);
      s = 8'($urandom);
      start_frame(3'd1, s);
      run_frame(3'd1, s, 0, NPIX - 1, -1);
      start_frame(3'd2, 8'h10);
      run_frame(3'd2, 8'h10, 0, -1, -1);
   endtask

   task automatic test_reset_abort();
      logic [7:0] s;
      s = 8'($urandom);
      start_frame(3'd3, s);
      run_frame(3'd3, s, 0, -1, 200);
      #2;
      resetn = 1'b0;
      #1;
      exp_frames = 0;
      checks++;
      if (we !== 1'b0 || waddr !== '0 || wdata !== 8'd0 || busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: we=%0b waddr=%0d wdata=%02h busy=%0b frame_done=%0b, required all 0",
                  we, waddr, wdata, busy, frame_done);
      end
`ifdef FBW_FRAME_COUNT_EN
      checks++;
      if (frame_count !== 16'd0) begin
         errors++;
         $display("FAIL async_reset_count: got %0d, required 0", frame_count);
      end
`endif
      s    = 8'($urandom);
      mode = 3'd1;
      seed = s;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1 || we !== 1'b0) begin
         errors++;
         $display("FAIL restart_after_reset: busy=%0b we=%0b, required 1 0", busy, we);
      end
      run_frame(3'd1, s, 2, -1, -1);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_auto_frame();
      test_done_hold();
      test_backpressure();
      test_checker();
      test_modes();
      test_start_ignored();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
